// File: rtl/hmac_msg_padder_pkg.sv
// Shared constants, FSM encoding and helpers for the HMAC-384 message padder.
package hmac_msg_padder_pkg;

    localparam int          BLOCK_W     = 1024;
    localparam int          WORD_W      = 32;
    localparam int          WORDS       = BLOCK_W / WORD_W;
    localparam int          LEN_FIELD_W = 128;
    localparam int          LEN_WORD0   = 28;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL       = 2'd0,
        ST_EMIT       = 2'd1,
        ST_EMIT_PADX  = 2'd2,
        ST_EMIT_FINAL = 2'd3
    } padder_state_t;

    // Message bit length as carried in the trailing 128-bit field.
    function automatic logic [LEN_FIELD_W-1:0] len_field(
        input logic [LEN_FIELD_W-1:0] offset_bits,
        input logic [LEN_FIELD_W-1:0] byte_cnt
    );
        return offset_bits + (byte_cnt << 3);
    endfunction

    // Keeps the n leading bytes and, on the last word, appends the pad byte after them.
    function automatic logic [WORD_W-1:0] pad_word(
        input logic [WORD_W-1:0] data,
        input logic [2:0]        n_bytes,
        input logic              last
    );
        logic [7:0] pad;
        pad = last ? PAD_BYTE : 8'h00;
        case (n_bytes)
            3'd0:    return {pad, 24'h0};
            3'd1:    return {data[31:24], pad, 16'h0};
            3'd2:    return {data[31:16], pad, 8'h0};
            3'd3:    return {data[31:8], pad};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/hmac_msg_padder.sv
// Packs a big-endian 32-bit word stream into 1024-bit SHA-384 blocks with padding
// and a length field that includes the preceding key^ipad block.
//
// state         | meaning
// ST_FILL       | accepting message words into the block buffer
// ST_EMIT       | full data block offered, more message to follow
// ST_EMIT_PADX  | last data block offered; padding/length spill into an extra block
// ST_EMIT_FINAL | block carrying the length field offered
module hmac_msg_padder
    import hmac_msg_padder_pkg::*;
#(
    parameter int LEN_OFFSET_BITS = 1024,
    parameter int LEN_W           = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                zeroize,
    input  logic                msg_valid,
    output logic                msg_ready,
    input  logic [WORD_W-1:0]   msg_data,
    input  logic                msg_last,
    input  logic [2:0]          msg_bytes,
    output logic                blk_valid,
    input  logic                blk_ready,
    output logic [BLOCK_W-1:0]  blk_data,
    output logic                blk_first,
    output logic                blk_final
);

    padder_state_t       r_state;
    logic [WORD_W-1:0]   r_words [WORDS];
    logic [4:0]          r_widx;
    logic [LEN_W-1:0]    r_byte_cnt;
    logic                r_first_pend;
    logic                r_pad_ovf;
    logic                r_msg_ready;
    logic                r_blk_valid;
    logic                r_blk_first;
    logic                r_blk_final;

    logic [LEN_W:0]             w_cnt_sum;
    logic [LEN_W-1:0]           w_cnt_next;
    logic [LEN_FIELD_W-1:0]     w_len_fill;
    logic [LEN_FIELD_W-1:0]     w_len_held;
    logic                       w_full;
    logic [5:0]                 w_pad_idx;
    logic [WORD_W-1:0]          w_word;
    logic [BLOCK_W-1:0]         w_blk_data;

    // Byte counter saturates instead of wrapping.
    assign w_cnt_sum  = {1'b0, r_byte_cnt} + {{(LEN_W-2){1'b0}}, msg_bytes};
    assign w_cnt_next = w_cnt_sum[LEN_W] ? {LEN_W{1'b1}} : w_cnt_sum[LEN_W-1:0];
    assign w_len_fill = len_field(LEN_FIELD_W'(LEN_OFFSET_BITS), LEN_FIELD_W'(w_cnt_next));
    assign w_len_held = len_field(LEN_FIELD_W'(LEN_OFFSET_BITS), LEN_FIELD_W'(r_byte_cnt));
    assign w_full     = (msg_bytes == 3'd4);
    assign w_pad_idx  = {1'b0, r_widx} + {5'd0, w_full};
    assign w_word     = pad_word(msg_data, msg_bytes, msg_last);

    always_comb begin
        w_blk_data = '0;
        for (int i = 0; i < WORDS; i++) begin
            w_blk_data[(WORDS-1-i)*WORD_W +: WORD_W] = r_words[i];
        end
    end

    assign blk_data  = w_blk_data;
    assign msg_ready = r_msg_ready;
    assign blk_valid = r_blk_valid;
    assign blk_first = r_blk_first;
    assign blk_final = r_blk_final;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_FILL;
            r_widx       <= '0;
            r_byte_cnt   <= '0;
            r_first_pend <= 1'b1;
            r_pad_ovf    <= 1'b0;
            r_msg_ready  <= 1'b0;
            r_blk_valid  <= 1'b0;
            r_blk_first  <= 1'b0;
            r_blk_final  <= 1'b0;
            for (int i = 0; i < WORDS; i++) r_words[i] <= '0;
        end else if (zeroize) begin
            r_state      <= ST_FILL;
            r_widx       <= '0;
            r_byte_cnt   <= '0;
            r_first_pend <= 1'b1;
            r_pad_ovf    <= 1'b0;
            r_msg_ready  <= 1'b0;
            r_blk_valid  <= 1'b0;
            r_blk_first  <= 1'b0;
            r_blk_final  <= 1'b0;
            for (int i = 0; i < WORDS; i++) r_words[i] <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (!r_msg_ready) begin
                        r_msg_ready <= 1'b1;
                    end else if (msg_valid) begin
                        r_words[r_widx] <= w_word;
                        r_byte_cnt      <= w_cnt_next;
                        if (msg_last || r_widx == 5'd31) begin
                            r_msg_ready  <= 1'b0;
                            r_blk_valid  <= 1'b1;
                            r_blk_first  <= r_first_pend;
                            r_first_pend <= 1'b0;
                        end
                        if (msg_last) begin
                            if (w_full && r_widx != 5'd31)
                                r_words[r_widx + 5'd1] <= {PAD_BYTE, 24'h0};
                            if (w_pad_idx < 6'(LEN_WORD0)) begin
                                r_words[28] <= w_len_fill[127:96];
                                r_words[29] <= w_len_fill[95:64];
                                r_words[30] <= w_len_fill[63:32];
                                r_words[31] <= w_len_fill[31:0];
                                r_blk_final <= 1'b1;
                                r_state     <= ST_EMIT_FINAL;
                            end else begin
                                r_pad_ovf <= w_pad_idx[5];
                                r_state   <= ST_EMIT_PADX;
                            end
                        end else if (r_widx == 5'd31) begin
                            r_state <= ST_EMIT;
                        end else begin
                            r_widx <= r_widx + 5'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (blk_ready) begin
                        for (int i = 0; i < WORDS; i++) r_words[i] <= '0;
                        r_widx      <= '0;
                        r_msg_ready <= 1'b1;
                        r_blk_valid <= 1'b0;
                        r_blk_first <= 1'b0;
                        r_state     <= ST_FILL;
                    end
                end
                ST_EMIT_PADX: begin
                    // Pad-only block: 0x80 leads only when it did not fit in the data block.
                    if (blk_ready) begin
                        for (int i = 0; i < WORDS; i++) r_words[i] <= '0;
                        r_words[0]  <= r_pad_ovf ? {PAD_BYTE, 24'h0} : '0;
                        r_words[28] <= w_len_held[127:96];
                        r_words[29] <= w_len_held[95:64];
                        r_words[30] <= w_len_held[63:32];
                        r_words[31] <= w_len_held[31:0];
                        r_pad_ovf   <= 1'b0;
                        r_blk_first <= 1'b0;
                        r_blk_final <= 1'b1;
                        r_state     <= ST_EMIT_FINAL;
                    end
                end
                ST_EMIT_FINAL: begin
                    if (blk_ready) begin
                        for (int i = 0; i < WORDS; i++) r_words[i] <= '0;
                        r_widx       <= '0;
                        r_byte_cnt   <= '0;
                        r_first_pend <= 1'b1;
                        r_pad_ovf    <= 1'b0;
                        r_msg_ready  <= 1'b1;
                        r_blk_valid  <= 1'b0;
                        r_blk_first  <= 1'b0;
                        r_blk_final  <= 1'b0;
                        r_state      <= ST_FILL;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_hmac_msg_padder.sv
// Scoreboard bench for hmac_msg_padder: stimulus queues expected blocks, a monitor
// pops and compares on every accepted output block.
module tb_hmac_msg_padder;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          zeroize = 1'b0;
    logic          msg_valid = 1'b0;
    logic          msg_ready;
    logic [31:0]   msg_data = '0;
    logic          msg_last = 1'b0;
    logic [2:0]    msg_bytes = '0;
    logic          blk_valid;
    logic          blk_ready = 1'b1;
    logic [1023:0] blk_data;
    logic          blk_first;
    logic          blk_final;

    hmac_msg_padder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .zeroize   (zeroize),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_data  (msg_data),
        .msg_last  (msg_last),
        .msg_bytes (msg_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_final (blk_final)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1023:0] data;
        logic          first;
        logic          fin;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic chk_blk(input string name, input logic [1023:0] act, input logic [1023:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (act[1023-32*i -: 32] !== req[1023-32*i -: 32]) begin
                    $display("FAIL %s: word%0d got %h expected %h", name, i,
                             act[1023-32*i -: 32], req[1023-32*i -: 32]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [7:0] msg_byte(input int i, input int seed);
        return 8'((i * 7 + seed) & 255);
    endfunction

    // Reference padding: message, 0x80, zeros, 16-byte big-endian bit length.
    task automatic push_model(input int nbytes, input int seed);
        logic [7:0]  b [256];
        logic [63:0] len;
        int          total;
        exp_t        e;
        for (int i = 0; i < 256; i++) b[i] = 8'h00;
        for (int i = 0; i < nbytes; i++) b[i] = msg_byte(i, seed);
        b[nbytes] = 8'h80;
        total = ((nbytes + 17 + 127) / 128) * 128;
        len = 64'(1024 + 8 * nbytes);
        for (int k = 0; k < 8; k++) b[total-8+k] = len[63-8*k -: 8];
        for (int blk = 0; blk < total / 128; blk++) begin
            e.data = '0;
            for (int j = 0; j < 128; j++) e.data[1023-8*j -: 8] = b[blk*128+j];
            e.first = (blk == 0);
            e.fin   = (blk == total / 128 - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_hand(input logic [31:0] w0, input logic [31:0] w31);
        exp_t e;
        e.data = '0;
        e.data[1023:992] = w0;
        e.data[31:0] = w31;
        e.first = 1'b1;
        e.fin = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] n, input logic last);
        int guard;
        guard = 0;
        msg_data = d;
        msg_bytes = n;
        msg_last = last;
        msg_valid = 1'b1;
        @(negedge clk);
        while (!msg_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!msg_ready) begin
            n_checks++;
            $display("FAIL send_timeout: msg_ready got 0 expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        msg_last = 1'b0;
    endtask

    task automatic send_msg(input int nbytes, input int seed);
        logic [31:0] w;
        int          rem;
        int          n;
        if (nbytes == 0) begin
            send_word(32'h5A5A5A5A, 3'd0, 1'b1);
        end else begin
            for (int off = 0; off < nbytes; off += 4) begin
                rem = nbytes - off;
                n = (rem >= 4) ? 4 : rem;
                w = 32'hA5A5A5A5;
                for (int k = 0; k < n; k++) w[31-8*k -: 8] = msg_byte(off + k, seed);
                send_word(w, 3'(n), rem <= 4);
            end
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: pending blocks got %0d expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_msg_ready"}, 64'(msg_ready), 64'd0);
        chk({tag, "_blk_valid"}, 64'(blk_valid), 64'd0);
        chk({tag, "_blk_first"}, 64'(blk_first), 64'd0);
        chk({tag, "_blk_final"}, 64'(blk_final), 64'd0);
        chk_blk({tag, "_blk_data"}, blk_data, '0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && blk_valid && blk_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_block: got a block expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk_blk("blk_data", blk_data, mon_e.data);
                    chk("blk_first", 64'(blk_first), 64'(mon_e.first));
                    chk("blk_final", 64'(blk_final), 64'(mon_e.fin));
                end
            end
        end
    end

    initial begin
        logic [1023:0] held;
        int            guard;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_first_cycle", 64'(msg_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("ready_after_reset", 64'(msg_ready), 64'd1);

        // T1 "abc"
        push_hand(32'h61626380, 32'h00000418);
        send_word(32'h61626300, 3'd3, 1'b1);
        chk("latency_valid", 64'(blk_valid), 64'd1);
        wait_drain();

        // T2 empty message
        push_hand(32'h80000000, 32'h00000400);
        send_word(32'h5A5A5A5A, 3'd0, 1'b1);
        wait_drain();

        // T3/T4 padding boundaries
        push_model(111, 3);
        send_msg(111, 3);
        push_model(112, 9);
        send_msg(112, 9);
        push_model(128, 17);
        send_msg(128, 17);
        push_model(13, 5);
        send_msg(13, 5);
        wait_drain();

        // T5 back-pressure on the first block of a 140-byte message
        blk_ready = 1'b0;
        push_model(140, 21);
        fork
            send_msg(140, 21);
            begin
                guard = 0;
                @(negedge clk);
                while (!blk_valid && guard < 400) begin
                    @(negedge clk);
                    guard++;
                end
                chk("hold_valid_seen", 64'(blk_valid), 64'd1);
                held = blk_data;
                repeat (5) begin
                    @(negedge clk);
                    chk_blk("hold_data", blk_data, held);
                    chk("hold_ready", 64'(msg_ready), 64'd0);
                    chk("hold_valid", 64'(blk_valid), 64'd1);
                end
                @(posedge clk);
                #1;
                blk_ready = 1'b1;
            end
        join
        wait_drain();

        // zeroize mid-fill aborts the partial message
        for (int i = 0; i < 5; i++) send_word(32'h11111111 * 32'(i + 1), 3'd4, 1'b0);
        zeroize = 1'b1;
        @(posedge clk);
        #1;
        zeroize = 1'b0;
        chk("zeroize_ready", 64'(msg_ready), 64'd0);
        chk("zeroize_valid", 64'(blk_valid), 64'd0);
        push_model(5, 33);
        send_msg(5, 33);
        wait_drain();

        // T6 async reset mid-block
        for (int i = 0; i < 10; i++) send_word(32'h01020304 + 32'(i), 3'd4, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_hand(32'h61626380, 32'h00000418);
        send_word(32'h61626300, 3'd3, 1'b1);
        wait_drain();

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
